cdb_arbiter: RTL and testbench

//  Producer side of the common data bus (CDB) that the reservation stations, ROB and PRF listen to.

---
 rtl/cdb_arbiter_if.sv | 50 +++++
 rtl/cdb_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Bundle between the completing functional units and the CDB producer.
// The master side is the set of functional units plus the CDB listeners,
// the slave side is the arbiter that buffers completions and drives the CDB.
interface cdb_arbiter_if #(
    parameter int PREG_WIDTH = 7,
    parameter int ROB_WIDTH  = 4,
    parameter int NUM_SRC    = 3
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Completion side, one lane per functional unit
    logic [NUM_SRC-1:0]            i_fu_valid;
    logic [NUM_SRC*PREG_WIDTH-1:0] i_fu_prd;
    logic [NUM_SRC*ROB_WIDTH-1:0]  i_fu_rob_tag;
    logic [NUM_SRC*32-1:0]         i_fu_data;
    logic [NUM_SRC-1:0]            o_fu_ready;

    // Broadcast side
    logic                          o_cdb_valid;
    logic [PREG_WIDTH-1:0]         o_cdb_prd;
    logic [ROB_WIDTH-1:0]          o_cdb_rob_tag;
    logic [31:0]                   o_cdb_data;
    logic [SRC_W-1:0]              o_cdb_src;

    modport master (
        output i_fu_valid,
        output i_fu_prd,
        output i_fu_rob_tag,
        output i_fu_data,
        input  o_fu_ready,
        input  o_cdb_valid,
        input  o_cdb_prd,
        input  o_cdb_rob_tag,
        input  o_cdb_data,
        input  o_cdb_src
    );

    modport slave (
        input  i_fu_valid,
        input  i_fu_prd,
        input  i_fu_rob_tag,
        input  i_fu_data,
        output o_fu_ready,
        output o_cdb_valid,
        output o_cdb_prd,
        output o_cdb_rob_tag,
        output o_cdb_data,
        output o_cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus producer.
// Each functional unit owns a small compacting queue of finished results.
// One result per cycle is granted onto the CDB by round-robin across the
// non-empty queues. A branch mispredict squashes every buffered or incoming
// result that is younger than the branch, measured from the ROB head so that
// tag wrap-around is handled naturally in ROB_WIDTH-bit arithmetic.
module cdb_arbiter #(
    parameter int PREG_WIDTH = 7,
    parameter int ROB_WIDTH  = 4,
    parameter int NUM_SRC    = 3,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    cdb_arbiter_if.slave         bus,
    input  logic [ROB_WIDTH-1:0] i_rob_head,
    input  logic                 branch_mispredict,
    input  logic [ROB_WIDTH-1:0] mispredict_rob_tag
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    // Age relative to the ROB head; larger age means younger instruction.
    function automatic logic is_younger(
        input logic [ROB_WIDTH-1:0] tag,
        input logic [ROB_WIDTH-1:0] head,
        input logic [ROB_WIDTH-1:0] ref_age
    );
        logic [ROB_WIDTH-1:0] age;
        age = tag - head;
        return (age > ref_age);
    endfunction

    logic                          ready_en_reg;
    logic [SRC_W-1:0]              rr_ptr_reg;
    logic [SRC_W-1:0]              rr_ptr_next;
    logic [ROB_WIDTH-1:0]          mispredict_age;

    logic [NUM_SRC-1:0]            cand;
    logic [NUM_SRC-1:0]            fu_ready;
    logic [NUM_SRC-1:0]            pop;
    logic [NUM_SRC*PREG_WIDTH-1:0] head_prd;
    logic [NUM_SRC*ROB_WIDTH-1:0]  head_tag;
    logic [NUM_SRC*32-1:0]         head_data;

    logic                          grant;
    logic [SRC_W-1:0]              winner;

    logic                          cdb_valid;
    logic [PREG_WIDTH-1:0]         cdb_prd;
    logic [ROB_WIDTH-1:0]          cdb_rob_tag;
    logic [31:0]                   cdb_data;
    logic [SRC_W-1:0]              cdb_src;

    assign mispredict_age = mispredict_rob_tag - i_rob_head;

    // Ready is held low through reset and for the first cycle after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    // Per-source result queues: slot 0 is always the oldest accepted entry.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [PREG_WIDTH-1:0] prd_mem   [BUF_DEPTH];
        logic [ROB_WIDTH-1:0]  tag_mem   [BUF_DEPTH];
        logic [31:0]           data_mem  [BUF_DEPTH];
        logic [PREG_WIDTH-1:0] prd_next  [BUF_DEPTH];
        logic [ROB_WIDTH-1:0]  tag_next  [BUF_DEPTH];
        logic [31:0]           data_next [BUF_DEPTH];
        logic [CNT_W-1:0]      count_reg;
        logic [CNT_W-1:0]      count_next;
        logic [CNT_W-1:0]      wr_idx;

        logic [PREG_WIDTH-1:0] in_prd;
        logic [ROB_WIDTH-1:0]  in_tag;
        logic [31:0]           in_data;
        logic                  accept;

        assign in_prd  = bus.i_fu_prd[gi*PREG_WIDTH +: PREG_WIDTH];
        assign in_tag  = bus.i_fu_rob_tag[gi*ROB_WIDTH +: ROB_WIDTH];
        assign in_data = bus.i_fu_data[gi*32 +: 32];

        // Credit is based on the registered count only; a pop in the same
        // cycle does not open an extra slot.
        assign fu_ready[gi] = ready_en_reg && !reset
                              && (count_reg < CNT_W'(BUF_DEPTH));
        assign accept       = bus.i_fu_valid[gi] && fu_ready[gi];
        assign cand[gi]     = (count_reg != '0);
        assign pop[gi]      = grant && (winner == SRC_W'(gi));

        assign head_prd[gi*PREG_WIDTH +: PREG_WIDTH] = prd_mem[0];
        assign head_tag[gi*ROB_WIDTH +: ROB_WIDTH]   = tag_mem[0];
        assign head_data[gi*32 +: 32]                = data_mem[0];

        // Rebuild the queue: drop the popped head and squashed entries,
        // pack survivors from slot 0 in order, then append a kept arrival.
        always_comb begin
            wr_idx = '0;
            for (int j = 0; j < BUF_DEPTH; j++) begin
                prd_next[j]  = prd_mem[j];
                tag_next[j]  = tag_mem[j];
                data_next[j] = data_mem[j];
            end
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if ((CNT_W'(i) < count_reg)
                    && !(pop[gi] && (i == 0))
                    && !(branch_mispredict
                         && is_younger(tag_mem[i], i_rob_head, mispredict_age))) begin
                    for (int j = 0; j < BUF_DEPTH; j++) begin
                        if (CNT_W'(j) == wr_idx) begin
                            prd_next[j]  = prd_mem[i];
                            tag_next[j]  = tag_mem[i];
                            data_next[j] = data_mem[i];
                        end
                    end
                    wr_idx = wr_idx + 1'b1;
                end
            end
            // A squashed arrival still completes its handshake but is not stored.
            if (accept && !(branch_mispredict
                            && is_younger(in_tag, i_rob_head, mispredict_age))) begin
                for (int j = 0; j < BUF_DEPTH; j++) begin
                    if (CNT_W'(j) == wr_idx) begin
                        prd_next[j]  = in_prd;
                        tag_next[j]  = in_tag;
                        data_next[j] = in_data;
                    end
                end
                wr_idx = wr_idx + 1'b1;
            end
            count_next = wr_idx;
        end

        // Occupancy is the only queue state that needs a reset value.
        always_ff @(posedge clk) begin
            if (reset) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_next;
            end
        end

        // Payload slots are plain storage, qualified by the occupancy count.
        always_ff @(posedge clk) begin
            for (int j = 0; j < BUF_DEPTH; j++) begin
                prd_mem[j]  <= prd_next[j];
                tag_mem[j]  <= tag_next[j];
                data_mem[j] <= data_next[j];
            end
        end
    end

    // Round-robin pick: first non-empty source at or after rr_ptr, wrapping.
    // No grant during reset or in a mispredict recovery cycle.
    always_comb begin
        int idx;
        idx    = 0;
        grant  = 1'b0;
        winner = '0;
        if (!reset && !branch_mispredict) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                idx = int'(rr_ptr_reg) + k;
                if (idx >= NUM_SRC) begin
                    idx = idx - NUM_SRC;
                end
                if (!grant && cand[idx]) begin
                    grant  = 1'b1;
                    winner = SRC_W'(idx);
                end
            end
        end
    end

    // Pointer moves just past the winner; it holds when nothing is granted.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant) begin
            if (winner == SRC_W'(NUM_SRC - 1)) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = winner + 1'b1;
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Broadcast the head of the winning queue; everything is zero when idle.
    always_comb begin
        cdb_valid   = 1'b0;
        cdb_prd     = '0;
        cdb_rob_tag = '0;
        cdb_data    = '0;
        cdb_src     = '0;
        if (grant) begin
            cdb_valid   = 1'b1;
            cdb_prd     = head_prd[int'(winner)*PREG_WIDTH +: PREG_WIDTH];
            cdb_rob_tag = head_tag[int'(winner)*ROB_WIDTH +: ROB_WIDTH];
            cdb_data    = head_data[int'(winner)*32 +: 32];
            cdb_src     = winner;
        end
    end

    assign bus.o_fu_ready    = fu_ready;
    assign bus.o_cdb_valid   = cdb_valid;
    assign bus.o_cdb_prd     = cdb_prd;
    assign bus.o_cdb_rob_tag = cdb_rob_tag;
    assign bus.o_cdb_data    = cdb_data;
    assign bus.o_cdb_src     = cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter. Expected broadcasts are queued when the
// producing completion is driven and popped as the CDB delivers them.
module tb_cdb_arbiter;
    localparam int PW = 7;
    localparam int RW = 4;
    localparam int NS = 3;
    localparam int BD = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [RW-1:0] rob_head = '0;
    logic          mp = 1'b0;
    logic [RW-1:0] mp_tag = '0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.PREG_WIDTH(PW), .ROB_WIDTH(RW), .NUM_SRC(NS)) bus ();

    cdb_arbiter #(
        .PREG_WIDTH(PW),
        .ROB_WIDTH (RW),
        .NUM_SRC   (NS),
        .BUF_DEPTH (BD)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus),
        .i_rob_head        (rob_head),
        .branch_mispredict (mp),
        .mispredict_rob_tag(mp_tag)
    );

    typedef struct packed {
        logic [1:0]    src;
        logic [PW-1:0] prd;
        logic [RW-1:0] tag;
        logic [31:0]   data;
    } cdb_t;

    cdb_t exp_q[$];
    int   tests = 0;
    int   errs  = 0;

    task automatic idle();
        bus.i_fu_valid   = '0;
        bus.i_fu_prd     = '0;
        bus.i_fu_rob_tag = '0;
        bus.i_fu_data    = '0;
        mp               = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    // Drive one completion on source s; push=1 records it as a future broadcast.
    task automatic put(input int s, input logic [PW-1:0] p, input logic [RW-1:0] t,
                       input logic [31:0] d, input bit push);
        cdb_t e;
        bus.i_fu_valid[s]          = 1'b1;
        bus.i_fu_prd[s*PW +: PW]   = p;
        bus.i_fu_rob_tag[s*RW +: RW] = t;
        bus.i_fu_data[s*32 +: 32]  = d;
        if (push) begin
            e.src  = 2'(s);
            e.prd  = p;
            e.tag  = t;
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    // Settle, then compare ready and the CDB against the expectation.
    task automatic chk(input bit ev, input logic [NS-1:0] er, input string nm);
        cdb_t got;
        cdb_t e;
        #1;
        tests++;
        assert (bus.o_fu_ready === er) else begin
            errs++;
            $error("FAIL %s ready: observed %b expected %b", nm, bus.o_fu_ready, er);
        end
        got = {bus.o_cdb_src, bus.o_cdb_prd, bus.o_cdb_rob_tag, bus.o_cdb_data};
        if (ev) begin
            tests++;
            assert (exp_q.size() > 0) else begin
                errs++;
                $error("FAIL %s scoreboard: observed empty queue expected an entry", nm);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                assert (bus.o_cdb_valid === 1'b1 && got === e) else begin
                    errs++;
                    $error("FAIL %s cdb: observed v=%0b src=%0d prd=%0d tag=%0d data=%h expected v=1 src=%0d prd=%0d tag=%0d data=%h",
                           nm, bus.o_cdb_valid, got.src, got.prd, got.tag, got.data,
                           e.src, e.prd, e.tag, e.data);
                end
                $display("[TB] %s cdb src=%0d prd=%0d tag=%0d data=%h",
                         nm, got.src, got.prd, got.tag, got.data);
            end
        end else begin
            tests++;
            assert (bus.o_cdb_valid === 1'b0 && got === '0) else begin
                errs++;
                $error("FAIL %s cdb idle: observed v=%0b src=%0d prd=%0d tag=%0d data=%h expected all zero",
                       nm, bus.o_cdb_valid, got.src, got.prd, got.tag, got.data);
            end
        end
    endtask

    task automatic do_reset(input string nm);
        step();
        reset = 1'b1;
        chk(1'b0, 3'b000, {nm, "_hold"});
        step();
        reset = 1'b0;
        chk(1'b0, 3'b000, {nm, "_release"});
        step();
        chk(1'b0, 3'b111, {nm, "_ready"});
    endtask

    // All three sources complete in the same cycle; rr_ptr must be 0.
    task automatic push_all_rr(input string nm, input logic [31:0] base);
        step();
        put(0, 7'd40, 4'd1, base + 32'd0, 1'b1);
        put(1, 7'd41, 4'd2, base + 32'd1, 1'b1);
        put(2, 7'd42, 4'd3, base + 32'd2, 1'b1);
        chk(1'b0, 3'b111, {nm, "_push"});
        step(); chk(1'b1, 3'b111, {nm, "_g0"});
        step(); chk(1'b1, 3'b111, {nm, "_g1"});
        step(); chk(1'b1, 3'b111, {nm, "_g2"});
        step(); chk(1'b0, 3'b111, {nm, "_idle"});
    endtask

    initial begin
        idle();
        @(posedge clk);
        do_reset("rst0");

        // Single ALU completion: one-cycle latency, then idle.
        step(); put(0, 7'd5, 4'd3, 32'hAA, 1'b1); chk(1'b0, 3'b111, "s1_push");
        step(); chk(1'b1, 3'b111, "s1_cdb");
        step(); chk(1'b0, 3'b111, "s1_empty");

        // Round-robin order from a fresh pointer, twice in a row.
        do_reset("rst1");
        push_all_rr("s2a", 32'h1000);
        push_all_rr("s2b", 32'h2000);

        // ALU streams while BR and LSU keep the CDB busy; ALU fills and stalls.
        step();
        put(0, 7'd10, 4'd0, 32'hA000, 1'b1);
        put(1, 7'd20, 4'd4, 32'hB000, 1'b1);
        put(2, 7'd30, 4'd8, 32'hC000, 1'b1);
        chk(1'b0, 3'b111, "s3_c0");
        step();
        put(0, 7'd11, 4'd1, 32'hA001, 1'b1);
        put(1, 7'd21, 4'd5, 32'hB001, 1'b1);
        put(2, 7'd31, 4'd9, 32'hC001, 1'b1);
        chk(1'b1, 3'b111, "s3_c1");
        step(); put(0, 7'd12, 4'd2, 32'hA002, 1'b1); chk(1'b1, 3'b001, "s3_c2");
        step(); put(0, 7'd13, 4'd3, 32'hA003, 1'b1); chk(1'b1, 3'b010, "s3_c3");
        step(); put(0, 7'd13, 4'd3, 32'hA003, 1'b0); chk(1'b1, 3'b110, "s3_c4");
        step(); put(0, 7'd13, 4'd3, 32'hA003, 1'b0); chk(1'b1, 3'b111, "s3_c5");
        step(); chk(1'b1, 3'b110, "s3_c6");
        step(); chk(1'b1, 3'b110, "s3_c7");
        step(); chk(1'b1, 3'b111, "s3_c8");
        step(); chk(1'b0, 3'b111, "s3_c9");

        // Wrap-aware flush: head=14, branch tag=1.
        rob_head = 4'd14;
        mp_tag   = 4'd1;
        step();
        put(0, 7'd50, 4'd15, 32'hD015, 1'b1);
        put(1, 7'd51, 4'd2,  32'hD002, 1'b0);
        put(2, 7'd52, 4'd13, 32'hD013, 1'b0);
        chk(1'b0, 3'b111, "s4_load");
        step(); mp = 1'b1; put(0, 7'd53, 4'd1, 32'hD001, 1'b1); chk(1'b0, 3'b111, "s4_flush");
        step(); chk(1'b1, 3'b110, "s4_g15");
        step(); chk(1'b1, 3'b111, "s4_g1");
        step(); chk(1'b0, 3'b111, "s4_idle");

        // Arrivals during the mispredict cycle: tag 0 kept, tag 5 dropped.
        step();
        mp = 1'b1;
        put(0, 7'd60, 4'd0, 32'hE000, 1'b1);
        put(1, 7'd61, 4'd5, 32'hE005, 1'b0);
        chk(1'b0, 3'b111, "s5_mp");
        step(); chk(1'b1, 3'b111, "s5_g0");
        step(); chk(1'b0, 3'b111, "s5_idle");

        // Reset with two sources holding entries discards them.
        rob_head = 4'd0;
        mp_tag   = 4'd0;
        step();
        put(0, 7'd70, 4'd6, 32'hF000, 1'b0);
        put(1, 7'd71, 4'd7, 32'hF001, 1'b0);
        chk(1'b0, 3'b111, "s6_load");
        do_reset("s6_rst");
        step(); chk(1'b0, 3'b111, "s6_empty");
        push_all_rr("s6_rr", 32'h3000);

        tests++;
        assert (exp_q.size() == 0) else begin
            errs++;
            $error("FAIL final_queue: observed %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
